// File: rtl/seq_shifter_if.sv
// Handshake and data bundle between the datapath controller (master) and seq_shifter (slave).
interface seq_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] sout;
  logic             carry;
  logic             busy;
  logic             done;

  modport master (
    output start, in, mode, amount,
    input  sout, carry, busy, done
  );

  modport slave (
    input  start, in, mode, amount,
    output sout, carry, busy, done
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: one bit position per clock, start/busy/done handshake,
// carry holds the last bit shifted out.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  seq_shifter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] MODE_LSL = 3'b001;
  localparam logic [2:0] MODE_LSR = 3'b010;
  localparam logic [2:0] MODE_ASR = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;
  localparam logic [AMT_W-1:0] ONE = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] sout_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] step_val;
  logic             step_carry;
  logic             accept;
  logic             is_pass;

  // Single-bit step for the latched mode; pass/reserved never reach SHIFT.
  always_comb begin
    step_val   = sout_q;
    step_carry = carry_q;
    case (mode_q)
      MODE_LSL: begin
        step_val   = {sout_q[WIDTH-2:0], 1'b0};
        step_carry = sout_q[WIDTH-1];
      end
      MODE_LSR: begin
        step_val   = {1'b0, sout_q[WIDTH-1:1]};
        step_carry = sout_q[0];
      end
      MODE_ASR: begin
        step_val   = {sout_q[WIDTH-1], sout_q[WIDTH-1:1]};
        step_carry = sout_q[0];
      end
      MODE_ROR: begin
        step_val   = {sout_q[0], sout_q[WIDTH-1:1]};
        step_carry = sout_q[0];
      end
      default: begin
        step_val   = sout_q;
        step_carry = carry_q;
      end
    endcase
  end

  assign accept  = bus.start && (state != SHIFT);
  assign is_pass = (bus.amount == '0) ||
                   !(bus.mode inside {MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROR});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mode_q  <= '0;
      count   <= '0;
      sout_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            sout_q <= bus.in;
            mode_q <= bus.mode;
            count  <= bus.amount;
            if (is_pass) begin
              state   <= DONE;
              carry_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state  <= SHIFT;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        SHIFT: begin
          sout_q  <= step_val;
          carry_q <= step_carry;
          count   <= count - ONE;
          if (count == ONE) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sout  = sout_q;
  assign bus.carry = carry_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: each scenario task drives stimulus and checks inline.
module tb_seq_shifter;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  seq_shifter_if #(.WIDTH(16), .AMT_W(4)) bus ();

  seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation; report latency (edges after E0), busy cycles, result and next-cycle done.
  task automatic do_op(input logic [15:0] a, input logic [2:0] m, input logic [3:0] amt,
                       output int lat, output int bcyc, output logic [15:0] s,
                       output logic c, output logic done_next);
    lat  = -1;
    bcyc = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.in = a; bus.mode = m; bus.amount = amt;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in = 16'h5A5A; bus.mode = 3'b001; bus.amount = 4'd3;
    for (int k = 0; k <= 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.busy === 1'b1) bcyc++;
      @(posedge clk); #1;
    end
    s = bus.sout;
    c = bus.carry;
    @(posedge clk); #1;
    done_next = bus.done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.in = '0; bus.mode = '0; bus.amount = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.sout, bus.carry, bus.busy, bus.done} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: got sout=%h carry=%b busy=%b done=%b, want all zero",
               bus.sout, bus.carry, bus.busy, bus.done);
    end
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    $display("test_reset: done");
  endtask

  task automatic test_lsl();
    int lat, bcyc; logic [15:0] s; logic c, dn;
    do_op(16'hF0CF, 3'b001, 4'd1, lat, bcyc, s, c, dn);
    checks++;
    if (lat !== 1 || bcyc !== 1) begin
      failures++;
      $display("FAIL lsl1_timing: got lat=%0d busy_cycles=%0d, want 1 1", lat, bcyc);
    end
    checks++;
    if (s !== 16'hE19E || c !== 1'b1) begin
      failures++;
      $display("FAIL lsl1_result: got sout=%h carry=%b, want e19e 1", s, c);
    end
    checks++;
    if (dn !== 1'b0) begin
      failures++;
      $display("FAIL lsl1_done_width: got done=%b one cycle later, want 0", dn);
    end
    $display("test_lsl: lat=%0d sout=%h carry=%b", lat, s, c);
  endtask

  task automatic test_lsr_asr();
    int lat, bcyc; logic [15:0] s; logic c, dn;
    do_op(16'hF0CF, 3'b010, 4'd4, lat, bcyc, s, c, dn);
    checks++;
    if (lat !== 4 || s !== 16'h0F0C || c !== 1'b1) begin
      failures++;
      $display("FAIL lsr4: got lat=%0d sout=%h carry=%b, want 4 0f0c 1", lat, s, c);
    end
    $display("test_lsr: lat=%0d sout=%h carry=%b", lat, s, c);
    do_op(16'hF0CF, 3'b011, 4'd4, lat, bcyc, s, c, dn);
    checks++;
    if (lat !== 4 || s !== 16'hFF0C || c !== 1'b1) begin
      failures++;
      $display("FAIL asr4: got lat=%0d sout=%h carry=%b, want 4 ff0c 1", lat, s, c);
    end
    $display("test_asr: lat=%0d sout=%h carry=%b", lat, s, c);
  endtask

  task automatic test_ror_asr15();
    int lat, bcyc; logic [15:0] s; logic c, dn;
    do_op(16'hF0CF, 3'b100, 4'd8, lat, bcyc, s, c, dn);
    checks++;
    if (lat !== 8 || bcyc !== 8 || s !== 16'hCFF0 || c !== 1'b1) begin
      failures++;
      $display("FAIL ror8: got lat=%0d busy_cycles=%0d sout=%h carry=%b, want 8 8 cff0 1",
               lat, bcyc, s, c);
    end
    $display("test_ror: lat=%0d sout=%h carry=%b", lat, s, c);
    do_op(16'h8000, 3'b011, 4'd15, lat, bcyc, s, c, dn);
    checks++;
    if (lat !== 15 || s !== 16'hFFFF || c !== 1'b0) begin
      failures++;
      $display("FAIL asr15: got lat=%0d sout=%h carry=%b, want 15 ffff 0", lat, s, c);
    end
    $display("test_asr15: lat=%0d sout=%h carry=%b", lat, s, c);
  endtask

  task automatic test_zero_pass();
    int lat, bcyc; logic [15:0] s; logic c, dn;
    // Leave carry=1 first so the clear on pass is observable.
    do_op(16'h8001, 3'b001, 4'd1, lat, bcyc, s, c, dn);
    do_op(16'hF0CF, 3'b001, 4'd0, lat, bcyc, s, c, dn);
    checks++;
    if (lat !== 0 || bcyc !== 0 || s !== 16'hF0CF || c !== 1'b0) begin
      failures++;
      $display("FAIL lsl_amt0: got lat=%0d busy_cycles=%0d sout=%h carry=%b, want 0 0 f0cf 0",
               lat, bcyc, s, c);
    end
    do_op(16'h8001, 3'b001, 4'd1, lat, bcyc, s, c, dn);
    do_op(16'hF0CF, 3'b110, 4'd5, lat, bcyc, s, c, dn);
    checks++;
    if (lat !== 0 || bcyc !== 0 || s !== 16'hF0CF || c !== 1'b0) begin
      failures++;
      $display("FAIL reserved_mode: got lat=%0d busy_cycles=%0d sout=%h carry=%b, want 0 0 f0cf 0",
               lat, bcyc, s, c);
    end
    $display("test_zero_pass: lat=%0d sout=%h carry=%b", lat, s, c);
  endtask

  task automatic test_back_to_back();
    int lat;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.in = 16'hF0CF; bus.mode = 3'b010; bus.amount = 4'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.in = 16'h1234; bus.mode = 3'b001; bus.amount = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 3; k <= 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 8 || bus.sout !== 16'h00F0 || bus.carry !== 1'b1) begin
      failures++;
      $display("FAIL ignore_start: got lat=%0d sout=%h carry=%b, want 8 00f0 1",
               lat, bus.sout, bus.carry);
    end
    bus.start = 1'b1; bus.in = 16'hF0CF; bus.mode = 3'b001; bus.amount = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", bus.busy, bus.done);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.sout !== 16'hE19E || bus.carry !== 1'b1) begin
      failures++;
      $display("FAIL b2b_result: got done=%b sout=%h carry=%b, want 1 e19e 1",
               bus.done, bus.sout, bus.carry);
    end
    $display("test_back_to_back: first lat=%0d second sout=%h", lat, bus.sout);
  endtask

  task automatic test_reset_abort();
    int lat, bcyc, spurious; logic [15:0] s; logic c, dn;
    spurious = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.in = 16'hF0CF; bus.mode = 3'b100; bus.amount = 4'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.sout, bus.carry, bus.busy, bus.done} !== 19'd0) begin
      failures++;
      $display("FAIL async_abort: got sout=%h carry=%b busy=%b done=%b, want all zero",
               bus.sout, bus.carry, bus.busy, bus.done);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL post_reset_idle: got %0d cycles with busy/done set, want 0", spurious);
    end
    do_op(16'hF0CF, 3'b010, 4'd4, lat, bcyc, s, c, dn);
    checks++;
    if (lat !== 4 || s !== 16'h0F0C || c !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_op: got lat=%0d sout=%h carry=%b, want 4 0f0c 1", lat, s, c);
    end
    $display("test_reset_abort: spurious=%0d next lat=%0d sout=%h", spurious, lat, s);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_lsl();
    test_lsr_asr();
    test_ror_asr15();
    test_zero_pass();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
